// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller: owns the PC, drives the instruction memory address and fills IF/ID.
// Optional build macro IFETCH_HALT_INSTR_EN makes 32'hFFFF_FFFF a halt marker instead of a normal word.
//
// state | meaning
// RUN   | fetching one word per cycle into IF/ID
// HALT  | PC frozen, IF/ID invalid; only a branch or reset leaves
module ifetch_ctrl #(
    parameter int          NumInst = 64,
    parameter logic [31:0] ResetPC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic        halted,
    output logic [31:0] fetch_count
);

    typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

    // 33 bits so the end-of-program compare is unsigned and cannot overflow.
    localparam logic [32:0] PcLimit = 33'(NumInst) << 2;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] instr_nxt, id_pc_nxt, id_pc4_nxt, count_nxt;
    logic        valid_nxt;
    logic        end_of_prog;
    logic        halt_marker;
    logic [31:0] pc_plus4;
    logic [31:0] redirect_pc;

`ifdef IFETCH_HALT_INSTR_EN
    assign halt_marker = (imem_instr == 32'hFFFF_FFFF);
`else
    assign halt_marker = 1'b0;
`endif

    assign pc_plus4    = pc + 32'd4;
    assign redirect_pc = {branch_target[31:2], 2'b00};
    assign end_of_prog = ({1'b0, pc} >= PcLimit);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            pc          <= ResetPC;
            if_id_instr <= '0;
            if_id_pc    <= '0;
            if_id_pc4   <= '0;
            if_id_valid <= 1'b0;
            fetch_count <= '0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            if_id_instr <= instr_nxt;
            if_id_pc    <= id_pc_nxt;
            if_id_pc4   <= id_pc4_nxt;
            if_id_valid <= valid_nxt;
            fetch_count <= count_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc;
        instr_nxt  = if_id_instr;
        id_pc_nxt  = if_id_pc;
        id_pc4_nxt = if_id_pc4;
        valid_nxt  = if_id_valid;
        count_nxt  = fetch_count;
        unique case (state)
            RUN: begin
                if (branch_taken) begin
                    // Squash the wrong-path word; data fields keep their old contents.
                    pc_nxt    = redirect_pc;
                    valid_nxt = 1'b0;
                end else if (stall) begin
                    // Everything holds.
                end else if (end_of_prog || halt_marker) begin
                    state_nxt = HALT;
                    valid_nxt = 1'b0;
                end else begin
                    instr_nxt  = imem_instr;
                    id_pc_nxt  = pc;
                    id_pc4_nxt = pc_plus4;
                    valid_nxt  = 1'b1;
                    pc_nxt     = pc_plus4;
                    count_nxt  = fetch_count + 32'd1;
                end
            end
            HALT: begin
                valid_nxt = 1'b0;
                if (branch_taken) begin
                    pc_nxt    = redirect_pc;
                    state_nxt = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    assign imem_addr = pc;
    assign halted    = (state == HALT);

endmodule
